// File: rtl/csr_timer_irq_gen.sv
// Machine timer + software interrupt source with a small CSR-style register window.
// Registered irq outputs (1-cycle latency); combinational rdata; no backpressure, writes always accepted.
module csr_timer_irq_gen #(
  parameter int unsigned PRESCALE   = 1,
  parameter logic [31:0] PERIOD_RST = 32'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        timer_irq,
  output logic        sw_irq,
  input  logic        timer_irq_ack
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [2:0] R_MTIME_LO = 3'd0;
  localparam logic [2:0] R_MTIME_HI = 3'd1;
  localparam logic [2:0] R_CMP_LO   = 3'd2;
  localparam logic [2:0] R_CMP_HI   = 3'd3;
  localparam logic [2:0] R_MSIP     = 3'd4;
  localparam logic [2:0] R_CTRL     = 3'd5;
  localparam logic [2:0] R_PERIOD   = 3'd6;

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [31:0]   period_q, period_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          timer_irq_q, timer_irq_d;
  logic          sw_irq_q, sw_irq_d;

  logic [2:0] idx;
  logic       tick;
  logic       unused_addr_bits;

  assign idx              = addr[4:2];
  assign unused_addr_bits = ^addr[1:0];
  assign tick             = ctrl_q[0] && (presc_q == PRESC_MAX);

  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    ctrl_d      = ctrl_q;
    period_d    = period_q;
    presc_d     = presc_q;
    timer_irq_d = ctrl_q[0] && (mtime_q >= mtimecmp_q);
    sw_irq_d    = msip_q;

    if (ctrl_q[0]) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) mtime_d = mtime_q + 64'd1;
    end

    // A software write to mtime overrides the increment and restarts the prescale phase.
    if (we && (idx == R_MTIME_LO)) begin
      mtime_d = {mtime_q[63:32], wdata};
      presc_d = '0;
    end else if (we && (idx == R_MTIME_HI)) begin
      mtime_d = {wdata, mtime_q[31:0]};
      presc_d = '0;
    end

    if (we && (idx == R_CMP_LO)) begin
      mtimecmp_d = {mtimecmp_q[63:32], wdata};
    end else if (we && (idx == R_CMP_HI)) begin
      mtimecmp_d = {wdata, mtimecmp_q[31:0]};
    end else if (ctrl_q[1] && timer_irq_ack && timer_irq_q) begin
      mtimecmp_d = mtimecmp_q + {32'd0, period_q};
    end

    if (we && (idx == R_MSIP))   msip_d   = wdata[0];
    if (we && (idx == R_CTRL))   ctrl_d   = wdata[1:0];
    if (we && (idx == R_PERIOD)) period_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      ctrl_q      <= 2'b00;
      period_q    <= PERIOD_RST;
      presc_q     <= '0;
      timer_irq_q <= 1'b0;
      sw_irq_q    <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      ctrl_q      <= ctrl_d;
      period_q    <= period_d;
      presc_q     <= presc_d;
      timer_irq_q <= timer_irq_d;
      sw_irq_q    <= sw_irq_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (idx)
      R_MTIME_LO: rdata = mtime_q[31:0];
      R_MTIME_HI: rdata = mtime_q[63:32];
      R_CMP_LO:   rdata = mtimecmp_q[31:0];
      R_CMP_HI:   rdata = mtimecmp_q[63:32];
      R_MSIP:     rdata = {31'd0, msip_q};
      R_CTRL:     rdata = {30'd0, ctrl_q};
      R_PERIOD:   rdata = period_q;
      default:    rdata = 32'd0;
    endcase
  end

  assign timer_irq = timer_irq_q;
  assign sw_irq    = sw_irq_q;

endmodule

// File: tb/tb_csr_timer_irq_gen.sv
// Bench: two timer instances (PRESCALE 1 and 4) share stimulus; a reference model feeds a scoreboard.
module tb_csr_timer_irq_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic        ack;
  logic [31:0] rdata0, rdata1;
  logic        tirq0, tirq1, sirq0, sirq1;

  always #5 clk = ~clk;

  csr_timer_irq_gen #(.PRESCALE(1), .PERIOD_RST(32'd100)) dut0 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata0),
    .timer_irq(tirq0), .sw_irq(sirq0), .timer_irq_ack(ack));

  csr_timer_irq_gen #(.PRESCALE(4), .PERIOD_RST(32'd100)) dut1 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata1),
    .timer_irq(tirq1), .sw_irq(sirq1), .timer_irq_ack(ack));

  // Reference model: registers as plain values, prescaler as a cycle count modulo PRESCALE.
  int unsigned  m_div    [2] = '{1, 4};
  longint unsigned m_time[2];
  longint unsigned m_cmp [2];
  bit           m_msip   [2];
  bit [1:0]     m_ctrl   [2];
  bit [31:0]    m_period [2];
  int unsigned  m_phase  [2];
  bit           m_tirq   [2];
  bit           m_sirq   [2];
  bit           known = 1'b0;

  typedef struct {
    logic [31:0] rd0, rd1;
    logic        ti0, ti1, si0, si1;
    int          cyc;
  } exp_t;
  exp_t expq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  function automatic logic [31:0] model_read(int k, logic [4:0] a);
    case (a[4:2])
      3'd0: return m_time[k][31:0];
      3'd1: return m_time[k][63:32];
      3'd2: return m_cmp[k][31:0];
      3'd3: return m_cmp[k][63:32];
      3'd4: return {31'd0, m_msip[k]};
      3'd5: return {30'd0, m_ctrl[k]};
      3'd6: return m_period[k];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(int k, bit r, bit w, logic [4:0] a, logic [31:0] d, bit ak);
    longint unsigned nt, nc;
    int unsigned np;
    bit [2:0] sel;
    if (r) begin
      m_time[k] = 0; m_cmp[k] = 64'hFFFF_FFFF_FFFF_FFFF; m_msip[k] = 0; m_ctrl[k] = 0;
      m_period[k] = 100; m_phase[k] = 0; m_tirq[k] = 0; m_sirq[k] = 0;
      return;
    end
    sel = w ? a[4:2] : 3'd7;
    nt = m_time[k]; nc = m_cmp[k]; np = m_phase[k];
    if (m_ctrl[k][0]) begin
      np = (m_phase[k] + 1) % m_div[k];
      if (np == 0) nt = m_time[k] + 1;
    end
    if (sel == 3'd0) begin nt = {m_time[k][63:32], d}; np = 0; end
    if (sel == 3'd1) begin nt = {d, m_time[k][31:0]}; np = 0; end
    if (sel == 3'd2) nc = {m_cmp[k][63:32], d};
    else if (sel == 3'd3) nc = {d, m_cmp[k][31:0]};
    else if (m_ctrl[k][1] && ak && m_tirq[k]) nc = m_cmp[k] + longint'(m_period[k]);
    m_tirq[k] = m_ctrl[k][0] && (m_time[k] >= m_cmp[k]);
    m_sirq[k] = m_msip[k];
    if (sel == 3'd4) m_msip[k] = d[0];
    if (sel == 3'd5) m_ctrl[k] = d[1:0];
    if (sel == 3'd6) m_period[k] = d;
    m_time[k] = nt; m_cmp[k] = nc; m_phase[k] = np;
  endtask

  // One clock of stimulus: inputs change on the falling edge, expectation queued for this cycle.
  task automatic cyc(bit r, bit w, logic [4:0] a, logic [31:0] d, bit ak);
    exp_t e;
    @(negedge clk);
    rst = r; we = w; addr = a; wdata = d; ack = ak;
    cyc_n++;
    if (known) begin
      e.rd0 = model_read(0, a); e.rd1 = model_read(1, a);
      e.ti0 = m_tirq[0]; e.ti1 = m_tirq[1];
      e.si0 = m_sirq[0]; e.si1 = m_sirq[1];
      e.cyc = cyc_n;
      expq.push_back(e);
    end
    model_step(0, r, w, a, d, ak);
    model_step(1, r, w, a, d, ak);
    if (r) known = 1'b1;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    cyc(0, 1, a, d, 0);
  endtask

  task automatic idle(int n, logic [4:0] a);
    for (int i = 0; i < n; i++) cyc(0, 0, a, $urandom, 0);
  endtask

  task automatic wait_tirq0(int limit);
    int n = 0;
    while (!m_tirq[0] && n < limit) begin
      cyc(0, 0, 5'h08, 0, 0);
      n++;
    end
    n_cmp++;
    if (!m_tirq[0]) begin
      n_bad++;
      $display("FAIL wait_tirq0: timer_irq got 0 want 1 within %0d cycles", limit);
    end
  endtask

  task automatic chk(string nm, int cy, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cy, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rdata_p1",  e.cyc, rdata0, e.rd0);
        chk("rdata_p4",  e.cyc, rdata1, e.rd1);
        chk("tirq_p1",   e.cyc, {31'd0, tirq0}, {31'd0, e.ti0});
        chk("tirq_p4",   e.cyc, {31'd0, tirq1}, {31'd0, e.ti1});
        chk("sirq_p1",   e.cyc, {31'd0, sirq0}, {31'd0, e.si0});
        chk("sirq_p4",   e.cyc, {31'd0, sirq1}, {31'd0, e.si1});
      end
    end
  end

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; ack = 1'b0;

    // Reset and read back every offset, including an unmapped one.
    cyc(1, 0, 5'h00, 0, 0);
    cyc(1, 0, 5'h00, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 5'(i * 4), 0, 0);

    // Compare and one-shot clear.
    wr(5'h08, 32'd20); wr(5'h0C, 32'd0); wr(5'h14, 32'd1);
    idle(25, 5'h00);
    wr(5'h08, 32'd1000);
    idle(3, 5'h00);

    // Carry from low to high half, then full 64-bit wrap.
    wr(5'h00, 32'hFFFF_FFFE); wr(5'h04, 32'd0);
    for (int i = 0; i < 3; i++) begin cyc(0, 0, 5'h00, 0, 0); cyc(0, 0, 5'h04, 0, 0); end
    wr(5'h04, 32'hFFFF_FFFF); wr(5'h00, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin cyc(0, 0, 5'h00, 0, 0); cyc(0, 0, 5'h04, 0, 0); end

    // Periodic reload on ack, ack while idle, and ack colliding with a compare write.
    wr(5'h14, 32'd0); wr(5'h00, 32'd0); wr(5'h04, 32'd0);
    wr(5'h18, 32'd50); wr(5'h0C, 32'd0); wr(5'h08, 32'd30); wr(5'h14, 32'd3);
    wait_tirq0(200);
    idle(2, 5'h08);
    cyc(0, 0, 5'h08, 0, 1);
    idle(2, 5'h08);
    cyc(0, 0, 5'h08, 0, 1);
    idle(2, 5'h08);
    wait_tirq0(200);
    cyc(0, 1, 5'h08, 32'd500, 1);
    idle(3, 5'h08);

    // Prescaled counting and an mtime write mid-count.
    wr(5'h14, 32'd0); wr(5'h0C, 32'hFFFF_FFFF); wr(5'h00, 32'd0); wr(5'h04, 32'd0);
    wr(5'h14, 32'd1);
    idle(12, 5'h00);
    idle(2, 5'h00);
    wr(5'h00, 32'd7);
    idle(6, 5'h00);

    // Software irq, then reset while both interrupts are high.
    wr(5'h10, 32'd1);
    idle(2, 5'h10);
    wr(5'h0C, 32'd0); wr(5'h08, 32'd0);
    idle(3, 5'h08);
    cyc(1, 1, 5'h08, 32'd5, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 5'(i * 4), 0, 0);

    // Randomised traffic with compare values steered near mtime.
    for (int i = 0; i < 500; i++) begin
      a = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      d = $urandom;
      if (a[4:2] == 3'd2 && $urandom_range(0, 1) == 1) d = m_time[0][31:0] + $urandom_range(0, 40);
      if (a[4:2] == 3'd3 && $urandom_range(0, 3) != 0) d = m_time[0][63:32];
      if (a[4:2] == 3'd6) d = $urandom_range(1, 60);
      if (a[4:2] == 3'd1 && $urandom_range(0, 3) != 0) d = 32'd0;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, a, d, $urandom_range(0, 5) == 0);
    end

    @(negedge clk);
    #4;
    chk("queue_drained", cyc_n, 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
